// File: rtl/ritc_datapath_bus_master_pkg.sv
// Shared definitions for the RITC datapath bus master: command op codes,
// datapath register map, FSM state encoding and the latched command payload.
package ritc_datapath_bus_master_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned IDX_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_SCAN  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Datapath responder register map
  localparam logic [ADDR_W-1:0] ADDR_DP_CTRL     = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_BITSLIP     = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_IDELAY_VAL  = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_IDELAY_CTRL = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WSTB   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RSTB   = 3'd3,
    ST_RWAIT  = 3'd4,
    ST_RESP   = 3'd5,
    ST_GAPW   = 3'd6
  } state_e;

  // Command captured on accept and held for the whole operation
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dat;
    logic [IDX_W-1:0]  count;
  } cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ritc_datapath_bus_master.sv
// Bus initiator for the RITC datapath user register interface.
// Converts host WRITE/READ/SCAN commands into one-cycle sel/wr/rd strobes and
// returns read data; SCAN does auto-incrementing write + settled readback per step.
// Ports:
//   user_clk_i, rst_i (sync, active high)
//   cmd_*      : command handshake (valid/ready) with op, addresses, data, step count
//   abort_i    : early stop for SCAN
//   rsp_*      : response handshake with read data, step index and last flag
//   user_*     : register bus towards the datapath responder
//   busy_o     : high whenever the FSM is not idle
module ritc_datapath_bus_master
  import ritc_datapath_bus_master_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned GAP          = 1
) (
  input  logic              user_clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_rd_addr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [IDX_W-1:0]  cmd_count_i,
  input  logic              abort_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic [IDX_W-1:0]  rsp_idx_o,
  output logic              rsp_last_o,
  output logic              user_sel_o,
  output logic              user_wr_o,
  output logic              user_rd_o,
  output logic [ADDR_W-1:0] user_addr_o,
  output logic [DATA_W-1:0] user_dat_o,
  input  logic [DATA_W-1:0] user_dat_i,
  output logic              busy_o
);

  localparam int unsigned WAIT_MAX = max3(READ_LATENCY, SETTLE, GAP);
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [IDX_W-1:0]   step_q, step_d;
  logic               abort_seen_q, abort_seen_d;
  logic               more_q, more_d;
  logic               capture;
  logic               enter_gap;

  logic               cmd_ready_d, busy_d;
  logic               rsp_valid_d, rsp_last_d;
  logic [DATA_W-1:0]  rsp_dat_d;
  logic [IDX_W-1:0]   rsp_idx_d;
  logic               user_sel_d, user_wr_d, user_rd_d;
  logic [ADDR_W-1:0]  user_addr_d;
  logic [DATA_W-1:0]  user_dat_d;

  // Next-state and next-output logic; outputs are decoded from the state being entered
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    wait_d       = wait_q;
    step_d       = step_q;
    abort_seen_d = abort_seen_q;
    more_d       = more_q;
    capture      = 1'b0;
    enter_gap    = 1'b0;
    cmd_ready_d  = 1'b0;
    busy_d       = 1'b1;
    rsp_valid_d  = 1'b0;
    rsp_last_d   = 1'b0;
    rsp_dat_d    = '0;
    rsp_idx_d    = '0;
    user_sel_d   = 1'b0;
    user_wr_d    = 1'b0;
    user_rd_d    = 1'b0;
    user_addr_d  = '0;
    user_dat_d   = user_dat_o;

    // Abort only matters while a SCAN is in flight
    if (state_q != ST_IDLE && cmd_q.op == OP_SCAN && abort_i) begin
      abort_seen_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_d.op      = op_e'(cmd_op_i);
          cmd_d.addr    = cmd_addr_i;
          cmd_d.rd_addr = cmd_rd_addr_i;
          cmd_d.dat     = cmd_dat_i;
          cmd_d.count   = cmd_count_i;
          step_d        = '0;
          abort_seen_d  = 1'b0;
          more_d        = 1'b0;
          unique case (op_e'(cmd_op_i))
            OP_WRITE, OP_SCAN: state_d = ST_WSTB;
            OP_READ:           state_d = ST_RSTB;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_WSTB: begin
        if (cmd_q.op == OP_SCAN) begin
          if (SETTLE > 0) begin
            state_d = ST_SETTLE;
            wait_d  = WAIT_W'(SETTLE - 1);
          end else begin
            state_d = ST_RSTB;
          end
        end else begin
          more_d    = 1'b0;
          enter_gap = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (wait_q == '0) state_d = ST_RSTB;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ST_RSTB: begin
        if (READ_LATENCY > 0) begin
          state_d = ST_RWAIT;
          wait_d  = WAIT_W'(READ_LATENCY - 1);
        end else begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RWAIT: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          enter_gap = 1'b1;
          if (rsp_last_o) begin
            more_d = 1'b0;
          end else begin
            more_d = 1'b1;
            step_d = step_q + IDX_W'(1);
          end
        end
      end
      ST_GAPW: begin
        if (wait_q == '0) state_d = more_q ? ST_WSTB : ST_IDLE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Post-strobe idle time; with GAP=0 go straight to the follow-up state
    if (enter_gap) begin
      if (GAP > 0) begin
        state_d = ST_GAPW;
        wait_d  = WAIT_W'(GAP - 1);
      end else begin
        state_d = more_d ? ST_WSTB : ST_IDLE;
      end
    end

    unique case (state_d)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      ST_WSTB: begin
        user_sel_d  = 1'b1;
        user_wr_d   = 1'b1;
        user_addr_d = cmd_d.addr;
        user_dat_d  = cmd_d.dat + DATA_W'(step_d);
      end
      ST_RSTB, ST_RWAIT: begin
        user_sel_d  = (state_d == ST_RSTB);
        user_rd_d   = (state_d == ST_RSTB);
        user_addr_d = (cmd_d.op == OP_SCAN) ? cmd_d.rd_addr : cmd_d.addr;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_idx_d   = step_q;
        if (capture) begin
          rsp_dat_d  = user_dat_i;
          rsp_last_d = (cmd_q.op != OP_SCAN) || (step_q == cmd_q.count) || abort_seen_d;
        end else begin
          rsp_dat_d  = rsp_dat_o;
          rsp_last_d = rsp_last_o;
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      wait_q       <= '0;
      step_q       <= '0;
      abort_seen_q <= 1'b0;
      more_q       <= 1'b0;
      cmd_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_last_o   <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_idx_o    <= '0;
      user_sel_o   <= 1'b0;
      user_wr_o    <= 1'b0;
      user_rd_o    <= 1'b0;
      user_addr_o  <= '0;
      user_dat_o   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      wait_q       <= wait_d;
      step_q       <= step_d;
      abort_seen_q <= abort_seen_d;
      more_q       <= more_d;
      cmd_ready_o  <= cmd_ready_d;
      busy_o       <= busy_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_last_o   <= rsp_last_d;
      rsp_dat_o    <= rsp_dat_d;
      rsp_idx_o    <= rsp_idx_d;
      user_sel_o   <= user_sel_d;
      user_wr_o    <= user_wr_d;
      user_rd_o    <= user_rd_d;
      user_addr_o  <= user_addr_d;
      user_dat_o   <= user_dat_d;
    end
  end

endmodule

// File: tb/tb_ritc_datapath_bus_master.sv
// Self-checking bench for ritc_datapath_bus_master: a transaction-level model
// predicts every bus strobe and every response; a negedge monitor compares them.
module tb_ritc_datapath_bus_master;

  localparam int SETTLE_C = 4;

  typedef struct packed {
    logic        is_wr;
    logic [3:0]  addr;
    logic [31:0] dat;
  } stb_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [7:0]  idx;
    logic        last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr, cmd_rd_addr;
  logic [31:0] cmd_dat;
  logic [7:0]  cmd_count;
  logic        abort;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_dat;
  logic [7:0]  rsp_idx;
  logic        user_sel, user_wr, user_rd;
  logic [3:0]  user_addr;
  logic [31:0] user_dat_o, user_dat_i;
  logic        busy;

  always #5 clk = ~clk;

  ritc_datapath_bus_master dut (
    .user_clk_i   (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_addr_i   (cmd_addr),
    .cmd_rd_addr_i(cmd_rd_addr),
    .cmd_dat_i    (cmd_dat),
    .cmd_count_i  (cmd_count),
    .abort_i      (abort),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_idx_o    (rsp_idx),
    .rsp_last_o   (rsp_last),
    .user_sel_o   (user_sel),
    .user_wr_o    (user_wr),
    .user_rd_o    (user_rd),
    .user_addr_o  (user_addr),
    .user_dat_o   (user_dat_o),
    .user_dat_i   (user_dat_i),
    .busy_o       (busy)
  );

  // Responder: register file, addr 3 reads back the IDELAY value plus a status flag,
  // read data appears one cycle after the rd strobe.
  logic [31:0] rregs [16];
  logic [31:0] rd_q;
  assign user_dat_i = rd_q;

  function automatic logic [31:0] resp_read(input logic [3:0] a);
    if (a == 4'h3) return rregs[2] + 32'h100;
    return rregs[a];
  endfunction

  always @(posedge clk) begin
    if (user_sel && user_wr) rregs[user_addr] <= user_dat_o;
    if (user_sel && user_rd) rd_q <= resp_read(user_addr);
  end

  // Model state
  logic [31:0] mregs [16];
  stb_t exp_s[$];
  rsp_t exp_r[$];
  bit   cur_scan = 1'b0;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    return (a == 4'h3) ? mregs[2] + 32'h100 : mregs[a];
  endfunction

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  // Monitor statistics
  int          cyc = 0, last_wr_cyc = 0;
  int          n_wr = 0, n_rd = 0, n_rsp = 0, n_last = 0, stall_cycles = 0;
  logic [31:0] lw_dat, lr_dat, pd;
  logic [7:0]  lr_idx, pi;
  logic        lr_last, pl;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    stb_t es;
    rsp_t er;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (user_sel || user_wr || user_rd)
        chk("strobe_form", {user_sel, user_wr ^ user_rd}, 2'b11);
      if (user_wr || user_rd) begin
        if (exp_s.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          es = exp_s.pop_front();
          chk("strobe_kind", user_wr, es.is_wr);
          chk("strobe_addr", user_addr, es.addr);
          if (user_wr) chk("wr_data", user_dat_o, es.dat);
        end
        if (user_wr) begin
          n_wr++;
          last_wr_cyc = cyc;
          lw_dat = user_dat_o;
        end
        if (user_rd) begin
          n_rd++;
          if (cur_scan) chk("settle_gap", (cyc - last_wr_cyc - 1) >= SETTLE_C, 1);
        end
      end
      if (prev_stall)
        chk("rsp_hold", {rsp_valid, rsp_dat, rsp_idx, rsp_last}, {1'b1, pd, pi, pl});
      if (rsp_valid) chk("no_strobe_in_resp", {user_wr, user_rd}, 2'b00);
      if (rsp_valid && !rsp_ready) stall_cycles++;
      if (rsp_valid && rsp_ready) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          er = exp_r.pop_front();
          chk("rsp", {rsp_dat, rsp_idx, rsp_last}, {er.dat, er.idx, er.last});
        end
        n_rsp++;
        if (rsp_last) n_last++;
        lr_dat  = rsp_dat;
        lr_idx  = rsp_idx;
        lr_last = rsp_last;
      end
      prev_stall = rsp_valid && !rsp_ready;
      pd = rsp_dat;
      pi = rsp_idx;
      pl = rsp_last;
    end
  end

  // Push predictions, then offer the command until it is accepted
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] ra,
                      input logic [31:0] d, input logic [7:0] cnt, input int abort_at);
    stb_t s;
    rsp_t r;
    int   n;
    int   k;
    case (op)
      2'b00: begin
        s = '{is_wr: 1'b1, addr: a, dat: d};
        exp_s.push_back(s);
        mregs[a] = d;
      end
      2'b01: begin
        s = '{is_wr: 1'b0, addr: a, dat: 32'h0};
        exp_s.push_back(s);
        r = '{dat: model_read(a), idx: 8'h0, last: 1'b1};
        exp_r.push_back(r);
      end
      2'b10: begin
        n = (abort_at >= 0) ? abort_at + 1 : int'(cnt) + 1;
        for (int i = 0; i < n; i++) begin
          s = '{is_wr: 1'b1, addr: a, dat: d + 32'(i)};
          exp_s.push_back(s);
          mregs[a] = d + 32'(i);
          s = '{is_wr: 1'b0, addr: ra, dat: 32'h0};
          exp_s.push_back(s);
          r = '{dat: model_read(ra), idx: 8'(i), last: (i == int'(cnt)) || (i == abort_at)};
          exp_r.push_back(r);
        end
      end
      default: ;
    endcase
    cur_scan = (op == 2'b10);
    for (k = 0; k < 200; k++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("cmd_ready_seen", k < 200, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_rd_addr = ra;
    cmd_dat = d; cmd_count = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Run until all predictions are consumed and the master is idle; optional stall
  task automatic wait_idle(input int stall_idx, input int limit);
    int left = 0;
    bit stalled = 1'b0;
    int k;
    for (k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (left > 0) begin
        left--;
        rsp_ready = 1'b0;
      end else if (!stalled && stall_idx >= 0 && rsp_valid && rsp_ready &&
                   int'(rsp_idx) == stall_idx) begin
        rsp_ready = 1'b0;
        left = 9;
        stalled = 1'b1;
      end else begin
        rsp_ready = 1'b1;
      end
      if (exp_s.size() == 0 && exp_r.size() == 0 && !busy && rsp_ready) break;
    end
    chk("idle_reached", k < limit, 1);
  endtask

  int s_wr, s_rd, s_rsp, s_last, s_stall, bc, k;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_rd_addr = '0;
    cmd_dat = '0; cmd_count = '0; abort = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_idx, rsp_last, user_sel, user_wr, user_rd,
                       user_addr, busy}, '0);
    chk("reset_data", {rsp_dat, user_dat_o}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);

    // WRITE addr 1 = 5
    s_wr = n_wr;
    send(2'b00, 4'h1, 4'h0, 32'h5, 8'h0, -1);
    bc = 0;
    while (busy && bc < 50) begin bc++; @(posedge clk); #1; end
    chk("write_busy_cycles", bc, 2);
    wait_idle(-1, 100);
    chk("write_strobes", n_wr - s_wr, 1);
    chk("write_data_lit", lw_dat, 32'h5);

    // READ addr 2 after loading it with 0x1F
    send(2'b00, 4'h2, 4'h0, 32'h1F, 8'h0, -1);
    wait_idle(-1, 100);
    s_rsp = n_rsp;
    send(2'b01, 4'h2, 4'h0, 32'h0, 8'h0, -1);
    wait_idle(-1, 100);
    chk("read_rsp_count", n_rsp - s_rsp, 1);
    chk("read_rsp_lit", {lr_dat, lr_idx, lr_last}, {32'h1F, 8'h0, 1'b1});

    // SCAN with data wrap
    s_wr = n_wr; s_rd = n_rd; s_rsp = n_rsp; s_last = n_last;
    send(2'b10, 4'h2, 4'h3, 32'hFFFF_FFFE, 8'd3, -1);
    wait_idle(-1, 500);
    chk("scan_wr_count", n_wr - s_wr, 4);
    chk("scan_rd_count", n_rd - s_rd, 4);
    chk("scan_rsp_count", n_rsp - s_rsp, 4);
    chk("scan_last_count", n_last - s_last, 1);
    chk("scan_final_wr_lit", lw_dat, 32'h1);
    chk("scan_final_rsp_lit", {lr_dat, lr_idx, lr_last}, {32'h101, 8'd3, 1'b1});

    // SCAN count=9 aborted during SETTLE of step 2
    s_rsp = n_rsp; s_last = n_last;
    send(2'b10, 4'h2, 4'h3, 32'h10, 8'd9, 2);
    for (k = 0; k < 200; k++) begin
      if (user_wr && user_dat_o == 32'h12) break;
      @(posedge clk); #1;
    end
    chk("abort_step_seen", k < 200, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(-1, 500);
    chk("abort_rsp_count", n_rsp - s_rsp, 3);
    chk("abort_last_count", n_last - s_last, 1);
    chk("abort_final_rsp_lit", {lr_dat, lr_idx, lr_last}, {32'h112, 8'd2, 1'b1});

    // Full 256-step SCAN, response back-pressured 10 cycles at idx 7
    s_rsp = n_rsp; s_last = n_last; s_stall = stall_cycles;
    send(2'b10, 4'h1, 4'h1, 32'h1000, 8'd255, -1);
    wait_idle(7, 20000);
    chk("stall_cycles", stall_cycles - s_stall, 10);
    chk("big_rsp_count", n_rsp - s_rsp, 256);
    chk("big_last_count", n_last - s_last, 1);
    chk("big_final_rsp_lit", {lr_dat, lr_idx, lr_last}, {32'h10FF, 8'd255, 1'b1});

    // Reserved op: accepted, nothing happens
    s_wr = n_wr; s_rd = n_rd; s_rsp = n_rsp;
    send(2'b11, 4'h1, 4'h1, 32'hDEAD, 8'd0, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("rsvd_idle", {busy, cmd_ready}, 2'b01);
    chk("rsvd_no_traffic", {n_wr - s_wr, n_rd - s_rd, n_rsp - s_rsp}, '0);

    // Reset during RWAIT drops the read; a new READ then completes
    send(2'b01, 4'h2, 4'h0, 32'h0, 8'h0, -1);
    for (k = 0; k < 50; k++) begin
      if (user_rd) break;
      @(posedge clk); #1;
    end
    chk("rd_strobe_seen", k < 50, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ctrl", {cmd_ready, rsp_valid, rsp_idx, rsp_last, user_sel, user_wr, user_rd,
                        user_addr, busy}, '0);
    chk("midrst_data", {rsp_dat, user_dat_o}, '0);
    rst = 1'b0;
    chk("midrst_strobes_drained", exp_s.size(), 0);
    exp_r.delete();
    s_rsp = n_rsp;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_rsp", n_rsp - s_rsp, 0);
    send(2'b01, 4'h2, 4'h0, 32'h0, 8'h0, -1);
    wait_idle(-1, 100);
    chk("post_rst_read_lit", {lr_dat, lr_idx, lr_last}, {32'h12, 8'h0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
